// File: rtl/ro_odometer_pkg.sv
// Shared types and defaults for the RO odometer reader.
package ro_odometer_pkg;

  localparam int unsigned FREQ_W = 32;

  localparam logic [FREQ_W-1:0] DEFAULT_THRESHOLD = 32'd50;
  localparam int unsigned       DEFAULT_TIMEOUT   = 1024;

  // One-hot sweep controller states, matching the odometer controller style.
  typedef enum logic [8:0] {
    ST_INIT    = 9'b0_0000_0001,
    ST_IDLE    = 9'b0_0000_0010,
    ST_ARM     = 9'b0_0000_0100,
    ST_BLANK   = 9'b0_0000_1000,
    ST_WAIT    = 9'b0_0001_0000,
    ST_CAPTURE = 9'b0_0010_0000,
    ST_RELEASE = 9'b0_0100_0000,
    ST_NEXT    = 9'b0_1000_0000,
    ST_DONE    = 9'b1_0000_0000
  } state_e;

endpackage

// File: rtl/ro_diff_eval.sv
// Saturating aging difference, threshold compare and running-max update.
module ro_diff_eval
  import ro_odometer_pkg::*;
#(
  parameter logic [FREQ_W-1:0] THRESHOLD = DEFAULT_THRESHOLD
) (
  input  logic [FREQ_W-1:0] r_freq,
  input  logic [FREQ_W-1:0] s_freq,
  input  logic [FREQ_W-1:0] max_in,
  output logic [FREQ_W-1:0] diff_c,
  output logic [FREQ_W-1:0] max_c,
  output logic              aged_c
);

  logic [FREQ_W:0] sub;

  // Borrow bit of the widened subtraction selects saturation to zero.
  always_comb begin
    sub    = {1'b0, r_freq} - {1'b0, s_freq};
    diff_c = sub[FREQ_W] ? '0 : sub[FREQ_W-1:0];
    aged_c = (diff_c > THRESHOLD);
    max_c  = (diff_c > max_in) ? diff_c : max_in;
  end

endmodule

// File: rtl/ro_odometer_reader.sv
// Host-side sweep initiator for the RO lifecycle odometer.
module ro_odometer_reader
  import ro_odometer_pkg::*;
#(
  parameter int unsigned       NO_CDIR      = 8,
  parameter int unsigned       MUX_SEL_SIZE = $clog2(NO_CDIR),
  parameter logic [FREQ_W-1:0] THRESHOLD    = DEFAULT_THRESHOLD,
  parameter int unsigned       TIMEOUT      = DEFAULT_TIMEOUT,
  parameter int unsigned       TO_W         = $clog2(TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [FREQ_W-1:0]       r_freq,
  input  logic [FREQ_W-1:0]       s_freq,
  input  logic                    valid_out,
  output logic                    go,
  output logic                    en_out,
  output logic [MUX_SEL_SIZE-1:0] r_mux_sel,
  output logic [MUX_SEL_SIZE-1:0] s_mux_sel,
  output logic                    busy,
  output logic [FREQ_W-1:0]       diff,
  output logic [MUX_SEL_SIZE-1:0] diff_idx,
  output logic                    diff_valid,
  output logic [NO_CDIR-1:0]      aged_mask,
  output logic [FREQ_W-1:0]       max_diff,
  output logic                    done,
  output logic                    timeout_err
);

  state_e                  state_q, state_d;
  logic [MUX_SEL_SIZE-1:0] idx_q, idx_d;
  logic                    blank_q, blank_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;

  logic                    go_d, en_d, busy_d, diff_valid_d, done_d, to_err_d;
  logic [MUX_SEL_SIZE-1:0] sel_d, diff_idx_d;
  logic [FREQ_W-1:0]       diff_d, max_d;
  logic [NO_CDIR-1:0]      aged_d;

  logic [FREQ_W-1:0]       diff_c, max_c;
  logic                    aged_c;

  ro_diff_eval #(
    .THRESHOLD (THRESHOLD)
  ) u_diff_eval (
    .r_freq (r_freq),
    .s_freq (s_freq),
    .max_in (max_diff),
    .diff_c (diff_c),
    .max_c  (max_c),
    .aged_c (aged_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output decode; outputs are set up for the state being entered.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    blank_d      = blank_q;
    to_cnt_d     = to_cnt_q;
    go_d         = 1'b0;
    en_d         = 1'b0;
    busy_d       = busy;
    sel_d        = r_mux_sel;
    diff_d       = diff;
    diff_idx_d   = diff_idx;
    diff_valid_d = 1'b0;
    aged_d       = aged_mask;
    max_d        = max_diff;
    done_d       = 1'b0;
    to_err_d     = timeout_err;

    unique case (state_q)
      ST_INIT: begin
        go_d    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          aged_d   = '0;
          max_d    = '0;
          to_err_d = 1'b0;
          idx_d    = '0;
          sel_d    = '0;
          busy_d   = 1'b1;
          en_d     = 1'b1;
          state_d  = ST_ARM;
        end
      end
      ST_ARM: begin
        blank_d  = 1'b0;
        to_cnt_d = '0;
        state_d  = ST_BLANK;
      end
      ST_BLANK: begin
        to_cnt_d = '0;
        if (blank_q) begin
          state_d = ST_WAIT;
        end else begin
          blank_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (valid_out) begin
          state_d = ST_CAPTURE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
          if (to_cnt_d == TO_W'(TIMEOUT)) begin
            to_err_d = 1'b1;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_CAPTURE: begin
        diff_d       = diff_c;
        diff_idx_d   = idx_q;
        diff_valid_d = 1'b1;
        if (aged_c) begin
          aged_d[idx_q] = 1'b1;
        end
        max_d   = max_c;
        go_d    = 1'b1;
        state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (valid_out && go) begin
          state_d = ST_NEXT;
        end else begin
          go_d = 1'b1;
        end
      end
      ST_NEXT: begin
        if (idx_q == MUX_SEL_SIZE'(NO_CDIR - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + MUX_SEL_SIZE'(1);
          sel_d   = idx_d;
          en_d    = 1'b1;
          state_d = ST_ARM;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      blank_q     <= 1'b0;
      to_cnt_q    <= '0;
      go          <= 1'b0;
      en_out      <= 1'b0;
      r_mux_sel   <= '0;
      s_mux_sel   <= '0;
      busy        <= 1'b0;
      diff        <= '0;
      diff_idx    <= '0;
      diff_valid  <= 1'b0;
      aged_mask   <= '0;
      max_diff    <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      blank_q     <= blank_d;
      to_cnt_q    <= to_cnt_d;
      go          <= go_d;
      en_out      <= en_d;
      r_mux_sel   <= sel_d;
      s_mux_sel   <= sel_d;
      busy        <= busy_d;
      diff        <= diff_d;
      diff_idx    <= diff_idx_d;
      diff_valid  <= diff_valid_d;
      aged_mask   <= aged_d;
      max_diff    <= max_d;
      done        <= done_d;
      timeout_err <= to_err_d;
    end
  end

endmodule
